// File: rtl/axi_pkg.sv
// Shared AXI encodings and the state type for the cache-line burst master.
package axi_pkg;

  // AXI burst type, transfer size and response encodings.
  localparam logic [1:0] INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;
  localparam logic [1:0] DECERR  = 2'b11;

  // One transaction at a time: a read walks IDLE-AR-RD-DONE and a write
  // walks IDLE-AW-WR-BR-DONE.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    RD   = 3'd2,
    AW   = 3'd3,
    WR   = 3'd4,
    BR   = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/axi_line_master_if.sv
// AXI4 master-side bundle driven by axi_line_master.
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both high; a source holds valid and its payload steady
// until that edge, and ready may be asserted before or after valid.
interface axi_line_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);

  logic [ID_WIDTH-1:0]     m_awid;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [7:0]              m_awlen;
  logic [2:0]              m_awsize;
  logic [1:0]              m_awburst;
  logic                    m_awvalid;
  logic                    m_awready;

  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wlast;
  logic                    m_wvalid;
  logic                    m_wready;

  logic [ID_WIDTH-1:0]     m_bid;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_bready;

  logic [ID_WIDTH-1:0]     m_arid;
  logic [ADDR_WIDTH-1:0]   m_araddr;
  logic [7:0]              m_arlen;
  logic [2:0]              m_arsize;
  logic [1:0]              m_arburst;
  logic                    m_arvalid;
  logic                    m_arready;

  logic [ID_WIDTH-1:0]     m_rid;
  logic [DATA_WIDTH-1:0]   m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rlast;
  logic                    m_rvalid;
  logic                    m_rready;

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );

endinterface

// File: rtl/axi_line_buffer.sv
// One cache line of storage: whole-line load, single-word indexed write,
// single-word indexed read, plus the full line as a flat vector.
module axi_line_buffer #(
  parameter int LINE_WORDS = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_en,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] load_line,
  input  logic                             wr_en,
  input  logic [IW-1:0]                    wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [IW-1:0]                    rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_out
);

  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

  // Next contents: a whole-line load has priority over a single-word write.
  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_line;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data  = mem_q[rd_idx];
  assign line_out = mem_q;

endmodule

// File: rtl/axi_line_master.sv
// Turns one cache-line fill or writeback request into a single AXI4 INCR
// burst of LINE_WORDS 32-bit beats; one transaction outstanding at a time.
module axi_line_master
  import axi_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          LINE_WORDS = 8,
  parameter int          ID_WIDTH   = 1,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_rw,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wline,
  output logic                             rsp_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_rline,
  output logic                             rsp_err,
  axi_line_master_if.master                bus,
  output state_t                           dbg_state
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int CW = IW + 1;
  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(LINE_WORDS * 4 - 1));

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]     rsp_rline_q, rsp_rline_d;

  logic                  buf_load;
  logic                  buf_wr;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic [LINE_W-1:0]     buf_line;

  logic arvalid, rready, awvalid, wvalid, wlast, bready;

  axi_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (buf_load),
    .load_line (req_wline),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_q[IW-1:0]),
    .wr_data   (bus.m_rdata),
    .rd_idx    (cnt_q[IW-1:0]),
    .rd_data   (buf_rd_data),
    .line_out  (buf_line)
  );

  // Transaction sequencing: next state, beat counter, sticky error and the
  // channel valid/ready strobes, all decoded from the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          buf_load = 1'b1;
          addr_d   = req_addr & ALIGN_MASK;
          rw_d     = req_rw;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = req_rw ? AW : AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (bus.m_arready) state_d = RD;
      end
      RD: begin
        rready = 1'b1;
        if (bus.m_rvalid) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // A slave error, an early rlast or a missing final rlast all
          // mark the line bad; either rlast or the last beat ends the burst.
          if (bus.m_rresp != OKAY) err_d = 1'b1;
          if (bus.m_rlast != (cnt_q == LAST_BEAT)) err_d = 1'b1;
          if (bus.m_rlast || (cnt_q == LAST_BEAT)) state_d = DONE;
        end
      end
      AW: begin
        awvalid = 1'b1;
        if (bus.m_awready) state_d = WR;
      end
      WR: begin
        wvalid = 1'b1;
        wlast  = (cnt_q == LAST_BEAT);
        if (bus.m_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = BR;
        end
      end
      BR: begin
        bready = 1'b1;
        if (bus.m_bvalid) begin
          if (bus.m_bresp != OKAY) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill data becomes visible in the completion cycle and is then held
  // until the next fill completes; writebacks leave it untouched.
  always_comb begin
    rsp_rline   = rsp_rline_q;
    rsp_rline_d = rsp_rline_q;
    if (state_q == DONE && !rw_q) begin
      rsp_rline   = buf_line;
      rsp_rline_d = buf_line;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rsp_rline_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rsp_rline_q <= rsp_rline_d;
    end
  end

  assign bus.m_awid    = ID_WIDTH'(AXI_ID);
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awlen   = 8'(LINE_WORDS - 1);
  assign bus.m_awsize  = SIZE_4B;
  assign bus.m_awburst = INCR;
  assign bus.m_awvalid = awvalid;

  assign bus.m_wdata   = buf_rd_data;
  assign bus.m_wstrb   = '1;
  assign bus.m_wlast   = wlast;
  assign bus.m_wvalid  = wvalid;

  assign bus.m_bready  = bready;

  assign bus.m_arid    = ID_WIDTH'(AXI_ID);
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = 8'(LINE_WORDS - 1);
  assign bus.m_arsize  = SIZE_4B;
  assign bus.m_arburst = INCR;
  assign bus.m_arvalid = arvalid;

  assign bus.m_rready  = rready;

  assign dbg_state = state_q;

  // Response IDs carry no information with a single outstanding transaction.
  logic unused_ids;
  assign unused_ids = ^{bus.m_rid, bus.m_bid};

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: a cycle-level AXI slave driven from tasks, with
// expected lines, beats, errors and latencies computed from the burst rules.
module tb_axi_line_master;
  import axi_pkg::*;

  localparam int LW     = 8;
  localparam int LINE_W = LW * 32;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [31:0]       req_addr;
  logic [LINE_W-1:0] req_wline;
  logic              rsp_valid;
  logic [LINE_W-1:0] rsp_rline;
  logic              rsp_err;
  state_t            dbg_state;

  axi_line_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) bus ();

  axi_line_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LINE_WORDS (LW),
    .ID_WIDTH   (1),
    .AXI_ID     (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wline (req_wline),
    .rsp_valid (rsp_valid),
    .rsp_rline (rsp_rline),
    .rsp_err   (rsp_err),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: write beats still expected on the W channel, in order.
  logic [31:0]       exp_q[$];
  logic [LINE_W-1:0] last_fill;
  bit                fill_known;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle_slave();
    bus.m_arready = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = OKAY;
    bus.m_bid     = '0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = OKAY;
    bus.m_rlast   = 1'b0;
    bus.m_rid     = '0;
  endtask

  // One request through to its completion pulse.
  // rlast_beat: beat carrying rlast (>= LW means never); err_beat: beat with
  // err_resp (-1 none); wr_mode 0 = wready always, 1 = 1,0,1,0..., 2 = random.
  task automatic run_txn(input bit rw, input logic [31:0] addr, input logic [LINE_W-1:0] wline,
                         input logic [LINE_W-1:0] rline, input int ar_stall, input int aw_stall,
                         input int rlast_beat, input int err_beat, input logic [1:0] err_resp,
                         input logic [1:0] bresp_v, input int wr_mode, input bit r_gaps,
                         input bit chk_lat, input bit hold_req);
    logic [31:0]       exp_addr;
    logic [LINE_W-1:0] exp_line;
    bit                exp_err;
    int                nbeats, cyc, beat, stall_n;
    bit                done, aw_done, b_pend, w_ph, full_fill;

    // Reference model of the transaction outcome.
    exp_addr  = addr & ~32'(LW * 4 - 1);
    nbeats    = LW;
    full_fill = 1'b0;
    exp_line  = rline;
    exp_q.delete();
    if (!rw) begin
      nbeats    = (rlast_beat < LW) ? rlast_beat + 1 : LW;
      full_fill = (nbeats == LW);
      exp_err   = (rlast_beat != LW - 1) ||
                  (err_beat >= 0 && err_beat < nbeats && err_resp != OKAY);
    end else begin
      exp_err = (bresp_v != OKAY);
      for (int i = 0; i < LW; i++) exp_q.push_back(wline[i*32 +: 32]);
    end

    @(negedge clk);
    check_eq("req_ready_idle", LINE_W'(req_ready), LINE_W'(1));
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wline = wline;
    @(posedge clk);

    cyc = 0; beat = 0; stall_n = 0; done = 0; aw_done = 0; b_pend = 0; w_ph = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (hold_req) begin
        // A competing request that must be ignored until IDLE.
        req_rw   = ~rw;
        req_addr = ~addr;
      end else begin
        req_valid = 1'b0;
      end
      idle_slave();
      check_eq("req_ready_busy", LINE_W'(req_ready), LINE_W'(0));

      if (bus.m_bready) begin
        if (b_pend) begin
          bus.m_bvalid = 1'b1;
          bus.m_bresp  = bresp_v;
          b_pend       = 1'b0;
        end
      end

      if (bus.m_rready) begin
        if (beat < nbeats && (!r_gaps || $urandom_range(0, 2) != 0)) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = rline[beat*32 +: 32];
          bus.m_rlast  = (beat == rlast_beat);
          bus.m_rresp  = (beat == err_beat) ? err_resp : OKAY;
          bus.m_rid    = 1'(beat);
          beat++;
        end
      end

      if (bus.m_wvalid) begin
        check_eq("w_after_aw", LINE_W'(aw_done), LINE_W'(1));
        if (exp_q.size() == 0) begin
          check_eq("w_extra_beat", LINE_W'(bus.m_wvalid), LINE_W'(0));
        end else begin
          check_eq("wdata", LINE_W'(bus.m_wdata), LINE_W'(exp_q[0]));
          check_eq("wlast", LINE_W'(bus.m_wlast), LINE_W'(exp_q.size() == 1));
          check_eq("wstrb", LINE_W'(bus.m_wstrb), LINE_W'(4'hF));
          case (wr_mode)
            0:       bus.m_wready = 1'b1;
            1:       begin bus.m_wready = w_ph; w_ph = ~w_ph; end
            default: bus.m_wready = ($urandom_range(0, 1) == 1);
          endcase
          if (bus.m_wready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) b_pend = 1'b1;
          end
        end
      end

      if (bus.m_awvalid) begin
        check_eq("awaddr", LINE_W'(bus.m_awaddr), LINE_W'(exp_addr));
        check_eq("awlen", LINE_W'(bus.m_awlen), LINE_W'(LW - 1));
        check_eq("awsize_burst", LINE_W'({bus.m_awsize, bus.m_awburst, bus.m_awid}), LINE_W'({3'd2, 2'd1, 1'b0}));
        if (stall_n < aw_stall) begin
          stall_n++;
          bus.m_bvalid = 1'b1;
          check_eq("bready_in_aw", LINE_W'(bus.m_bready), LINE_W'(0));
        end else begin
          bus.m_awready = 1'b1;
          aw_done       = 1'b1;
        end
      end

      if (bus.m_arvalid) begin
        check_eq("araddr", LINE_W'(bus.m_araddr), LINE_W'(exp_addr));
        check_eq("arlen", LINE_W'(bus.m_arlen), LINE_W'(LW - 1));
        check_eq("arsize_burst", LINE_W'({bus.m_arsize, bus.m_arburst, bus.m_arid}), LINE_W'({3'd2, 2'd1, 1'b0}));
        if (stall_n < ar_stall) begin
          stall_n++;
          bus.m_rvalid = 1'b1;
          check_eq("rready_in_ar", LINE_W'(bus.m_rready), LINE_W'(0));
        end else begin
          bus.m_arready = 1'b1;
        end
      end

      if (rsp_valid) begin
        done      = 1'b1;
        req_valid = 1'b0;
        check_eq("rsp_err", LINE_W'(rsp_err), LINE_W'(exp_err));
        if (chk_lat) check_eq("latency", LINE_W'(cyc), LINE_W'(rw ? LW + 3 : LW + 2));
        if (rw) begin
          check_eq("w_beats_left", LINE_W'(exp_q.size()), LINE_W'(0));
          if (fill_known) check_eq("rline_kept_on_write", rsp_rline, last_fill);
        end else begin
          check_eq("r_beats_used", LINE_W'(beat), LINE_W'(nbeats));
          if (full_fill) check_eq("rsp_rline", rsp_rline, exp_line);
        end
      end
    end
    if (!done) check_eq("txn_timeout", LINE_W'(0), LINE_W'(1));

    if (!rw) begin
      fill_known = full_fill;
      last_fill  = exp_line;
    end

    @(negedge clk);
    idle_slave();
    check_eq("rsp_valid_pulse", LINE_W'(rsp_valid), LINE_W'(0));
    check_eq("req_ready_after", LINE_W'(req_ready), LINE_W'(1));
    if (fill_known) check_eq("rline_held", rsp_rline, last_fill);
  endtask

  // Start a zero-wait write and pull reset while beat 4 is on the bus.
  task automatic reset_mid_write();
    int wb;
    bit hit;
    wb  = 0;
    hit = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 32'h0000_4000;
    req_wline = mk_line(32'hC0);
    @(posedge clk);
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      idle_slave();
      if (bus.m_awvalid) bus.m_awready = 1'b1;
      if (bus.m_wvalid) begin
        if (wb == 4) hit = 1'b1;
        else begin
          bus.m_wready = 1'b1;
          wb++;
        end
      end
    end
    check_eq("reset_beat4_reached", LINE_W'(hit), LINE_W'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_wvalid", LINE_W'(bus.m_wvalid), LINE_W'(0));
    check_eq("rst_awvalid", LINE_W'(bus.m_awvalid), LINE_W'(0));
    check_eq("rst_bready", LINE_W'(bus.m_bready), LINE_W'(0));
    check_eq("rst_rsp_valid", LINE_W'(rsp_valid), LINE_W'(0));
    idle_slave();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_hold_rsp_valid", LINE_W'(rsp_valid), LINE_W'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", LINE_W'(req_ready), LINE_W'(1));
    check_eq("rst_state", LINE_W'(dbg_state), LINE_W'(IDLE));
    last_fill  = '0;
    fill_known = 1'b1;
  endtask

  // Test sequence.
  initial begin
    logic [LINE_W-1:0] wl, rl;
    int                rlb, eb;
    logic [1:0]        er, br;
    bit                rw;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_wline  = '0;
    last_fill  = '0;
    fill_known = 1'b1;
    idle_slave();
    repeat (3) @(negedge clk);

    check_eq("reset_valids", LINE_W'({bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_wlast,
                                      bus.m_rready, bus.m_bready, rsp_valid}), LINE_W'(0));
    check_eq("reset_araddr", LINE_W'(bus.m_araddr), LINE_W'(0));
    check_eq("reset_awaddr", LINE_W'(bus.m_awaddr), LINE_W'(0));
    check_eq("reset_rline", rsp_rline, LINE_W'(0));
    check_eq("reset_state", LINE_W'(dbg_state), LINE_W'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_req_ready", LINE_W'(req_ready), LINE_W'(1));

    // Zero-wait fill of 0x1234 -> 0x1220, words 0xA0..0xA7.
    run_txn(0, 32'h0000_1234, '0, mk_line(32'hA0), 0, 0, LW - 1, -1, OKAY, OKAY, 0, 0, 1, 0);
    // Writeback 0xB0..0xB7 with wready toggling.
    run_txn(1, 32'h0000_2000, mk_line(32'hB0), '0, 0, 0, 0, -1, OKAY, OKAY, 1, 0, 0, 0);
    // Zero-wait writeback for latency.
    run_txn(1, 32'h0000_3018, mk_line(32'h10), '0, 0, 0, 0, -1, OKAY, OKAY, 0, 0, 1, 0);
    // Early rlast on beat 5.
    run_txn(0, 32'h0000_0100, '0, mk_line(32'h50), 0, 0, 5, -1, OKAY, OKAY, 0, 0, 0, 0);
    // SLVERR on beat 3, all beats accepted.
    run_txn(0, 32'h0000_0200, '0, mk_line(32'h60), 0, 0, LW - 1, 3, SLVERR, OKAY, 0, 0, 1, 0);
    // Writeback answered with DECERR.
    run_txn(1, 32'h0000_0300, mk_line(32'h70), '0, 0, 0, 0, -1, OKAY, DECERR, 0, 0, 0, 0);
    // arready held low 20 cycles with a competing request.
    run_txn(0, 32'h0000_5555, '0, mk_line(32'h80), 20, 0, LW - 1, -1, OKAY, OKAY, 0, 0, 0, 1);
    // awready held low with a competing request.
    run_txn(1, 32'h0000_6666, mk_line(32'h90), '0, 0, 5, 0, -1, OKAY, OKAY, 2, 0, 0, 1);
    // No rlast at all on the final beat.
    run_txn(0, 32'h0000_0400, '0, mk_line(32'hD0), 0, 0, 99, -1, OKAY, OKAY, 0, 0, 0, 0);

    reset_mid_write();
    run_txn(0, 32'h0000_7777, '0, mk_line(32'hE0), 0, 0, LW - 1, -1, OKAY, OKAY, 0, 0, 1, 0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      rw = ($urandom_range(0, 1) == 1);
      wl = rand_line();
      rl = rand_line();
      case ($urandom_range(0, 5))
        0:       rlb = $urandom_range(0, LW - 2);
        1:       rlb = 99;
        default: rlb = LW - 1;
      endcase
      eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, LW - 1) : -1;
      er = ($urandom_range(0, 1) == 1) ? SLVERR : DECERR;
      br = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : OKAY;
      run_txn(rw, $urandom, wl, rl, $urandom_range(0, 3), $urandom_range(0, 3),
              rlb, eb, er, br, 2, 1, 0, $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
